// File: rtl/layer_input_gather_if.sv
// Stream-in / vector-out bundle for the gather stage.
// slave: the gather block itself; master: the upstream/downstream environment.
`ifndef ZERO2ONE_MIN
`define ZERO2ONE_MIN 8'h00
`endif
`ifndef ZERO2ONE_MAX
`define ZERO2ONE_MAX 8'hFF
`endif

interface layer_input_gather_if #(
  parameter int N = 16
);
  typedef logic [7:0] zero2one_t;
  localparam int CW = $clog2(N + 1);

  logic                 in_valid;
  logic                 in_ready;
  zero2one_t            in_data;
  logic                 in_last;
  zero2one_t [N-1:0]    vec_out;
  logic                 vec_valid;
  logic                 vec_ready;
  logic [CW-1:0]        elem_count;
  logic                 short_vec;

  modport master (
    output in_valid, in_data, in_last, vec_ready,
    input  in_ready, vec_out, vec_valid, elem_count, short_vec
  );

  modport slave (
    input  in_valid, in_data, in_last, vec_ready,
    output in_ready, vec_out, vec_valid, elem_count, short_vec
  );
endinterface

// File: rtl/layer_input_gather.sv
// Serial-to-parallel gather: collects up to N activations into a fill buffer,
// then hands the padded vector to a registered output slot.
`ifndef ZERO2ONE_MIN
`define ZERO2ONE_MIN 8'h00
`endif
`ifndef ZERO2ONE_MAX
`define ZERO2ONE_MAX 8'hFF
`endif

module layer_input_gather #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  layer_input_gather_if.slave  bus
);
  typedef logic [7:0] zero2one_t;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    S_FILL,
    S_PEND
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q;
  zero2one_t [N-1:0] fill_q;
  zero2one_t [N-1:0] vec_out_q;
  logic              vec_valid_q;
  logic [CW-1:0]     elem_count_q;
  logic              short_q;

  logic              in_ready_c;
  logic              slot_free;
  logic              accept;
  logic              last_slot;
  logic              complete;
  logic              xfer_fill;
  logic              xfer_pend;
  logic [CW-1:0]     count_now;
  zero2one_t [N-1:0] assembled;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // Next-state: park in PEND when a vector completes but the slot is occupied
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILL: if (complete && !slot_free) state_d = S_PEND;
      S_PEND: if (bus.vec_ready)          state_d = S_FILL;
      default:                            state_d = S_FILL;
    endcase
  end

  // Handshake and transfer decode; in_ready is a function of state only (plus reset)
  always_comb begin
    in_ready_c = (state_q == S_FILL) && !rst;
    slot_free  = !vec_valid_q || bus.vec_ready;
    accept     = bus.in_valid && in_ready_c;
    last_slot  = (idx_q == IW'(N - 1));
    complete   = accept && (last_slot || bus.in_last);
    xfer_fill  = complete && slot_free;
    xfer_pend  = (state_q == S_PEND) && bus.vec_ready;
    count_now  = CW'(idx_q) + CW'(1);
  end

  // Current beat merged into the fill buffer; slots beyond idx are padded with
  // min (harmless on non-completing beats, later beats overwrite them)
  always_comb begin
    assembled = fill_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (IW'(i) == idx_q)     assembled[i] = bus.in_data;
      else if (IW'(i) > idx_q) assembled[i] = `ZERO2ONE_MIN;
    end
  end

  // Fill buffer, index and output slot. In PEND idx_q keeps the completing
  // index so the element count can be rebuilt at transfer time.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      fill_q       <= {N{`ZERO2ONE_MIN}};
      vec_out_q    <= {N{`ZERO2ONE_MIN}};
      vec_valid_q  <= 1'b0;
      elem_count_q <= '0;
      short_q      <= 1'b0;
    end else begin
      if (accept) fill_q <= assembled;

      if (xfer_fill || xfer_pend)   idx_q <= '0;
      else if (accept && !complete) idx_q <= idx_q + IW'(1);

      if (xfer_fill)      vec_out_q <= assembled;
      else if (xfer_pend) vec_out_q <= fill_q;

      if (xfer_fill || xfer_pend) begin
        elem_count_q <= count_now;
        short_q      <= !last_slot;
      end

      if (xfer_fill || xfer_pend) vec_valid_q <= 1'b1;
      else if (bus.vec_ready)     vec_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.vec_out    = vec_out_q;
  assign bus.vec_valid  = vec_valid_q;
  assign bus.elem_count = elem_count_q;
  assign bus.short_vec  = short_q;
endmodule

// File: tb/tb_layer_input_gather.sv
// Directed bench for layer_input_gather (N = 16).
module tb_layer_input_gather;
  localparam int N = 16;
  localparam int W = N * 8;
  typedef logic [7:0] z_t;
  localparam z_t ZMIN = 8'h00;
  localparam z_t ZMAX = 8'hFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_input_gather_if #(.N(N)) bus ();
  layer_input_gather #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  z_t [N-1:0] exp_v;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat, presented for one clock; in_ready must be high when presented
  task automatic beat(input z_t d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    chk("in_ready_at_beat", W'(bus.in_ready), W'(1));
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b1;          // ignored while in_valid = 0
    bus.in_data  = z_t'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.vec_ready = 1'b0;

    // ---- reset state
    tick(); tick();
    chk("rst_vec_valid", W'(bus.vec_valid), W'(0));
    chk("rst_in_ready", W'(bus.in_ready), W'(0));
    chk("rst_elem_count", W'(bus.elem_count), W'(0));
    chk("rst_short", W'(bus.short_vec), W'(0));
    chk("rst_vec_out", W'(bus.vec_out), {N{ZMIN}});
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", W'(bus.in_ready), W'(1));

    // ---- full vector 1..16 with vec_ready held
    bus.vec_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      beat(z_t'(i + 1), 1'b0);
      if (i == N - 2) chk("full_no_early_valid", W'(bus.vec_valid), W'(0));
    end
    for (int i = 0; i < N; i++) exp_v[i] = z_t'(i + 1);
    chk("full_valid", W'(bus.vec_valid), W'(1));
    chk("full_vec_out", W'(bus.vec_out), W'(exp_v));
    chk("full_count", W'(bus.elem_count), W'(16));
    chk("full_short", W'(bus.short_vec), W'(0));
    chk("full_in_ready", W'(bus.in_ready), W'(1));
    tick();
    chk("full_valid_pulse", W'(bus.vec_valid), W'(0));

    // ---- backpressure: A then B with vec_ready low
    bus.vec_ready = 1'b0;
    for (int i = 0; i < N; i++) beat(z_t'(8'h20 + i), 1'b0);
    for (int i = 0; i < N; i++) exp_v[i] = z_t'(8'h20 + i);
    chk("bp_a_valid", W'(bus.vec_valid), W'(1));
    chk("bp_a_vec_out", W'(bus.vec_out), W'(exp_v));
    for (int i = 0; i < N; i++) beat(z_t'(8'h40 + i), 1'b0);
    chk("bp_pend_in_ready", W'(bus.in_ready), W'(0));
    chk("bp_still_a", W'(bus.vec_out), W'(exp_v));
    tick();
    chk("bp_pend_hold_ready", W'(bus.in_ready), W'(0));
    chk("bp_pend_hold_a", W'(bus.vec_out), W'(exp_v));
    bus.vec_ready = 1'b1;
    tick();
    bus.vec_ready = 1'b0;
    for (int i = 0; i < N; i++) exp_v[i] = z_t'(8'h40 + i);
    chk("bp_b_vec_out", W'(bus.vec_out), W'(exp_v));
    chk("bp_b_valid", W'(bus.vec_valid), W'(1));
    chk("bp_b_in_ready", W'(bus.in_ready), W'(1));
    chk("bp_b_count", W'(bus.elem_count), W'(16));
    tick();
    chk("bp_b_held", W'(bus.vec_valid), W'(1));
    bus.vec_ready = 1'b1;
    tick();
    chk("bp_b_consumed", W'(bus.vec_valid), W'(0));

    // ---- short vector 9..13, last on beat 5
    for (int i = 0; i < 5; i++) beat(z_t'(9 + i), (i == 4));
    exp_v = {N{ZMIN}};
    for (int i = 0; i < 5; i++) exp_v[i] = z_t'(9 + i);
    chk("short_vec_out", W'(bus.vec_out), W'(exp_v));
    chk("short_count", W'(bus.elem_count), W'(5));
    chk("short_flag", W'(bus.short_vec), W'(1));
    chk("short_valid", W'(bus.vec_valid), W'(1));

    // ---- single element: max with last on first beat (lands in slot 0)
    beat(ZMAX, 1'b1);
    exp_v = {N{ZMIN}};
    exp_v[0] = ZMAX;
    chk("single_vec_out", W'(bus.vec_out), W'(exp_v));
    chk("single_count", W'(bus.elem_count), W'(1));
    chk("single_short", W'(bus.short_vec), W'(1));

    // ---- simultaneous consume and completion; last on 16th beat is not short
    bus.vec_ready = 1'b0;
    for (int i = 0; i < N - 1; i++) beat(z_t'(8'h60 + i), 1'b0);
    chk("sim_prev_held", W'(bus.vec_valid), W'(1));
    bus.vec_ready = 1'b1;
    beat(z_t'(8'h60 + N - 1), 1'b1);
    for (int i = 0; i < N; i++) exp_v[i] = z_t'(8'h60 + i);
    chk("sim_valid", W'(bus.vec_valid), W'(1));
    chk("sim_vec_out", W'(bus.vec_out), W'(exp_v));
    chk("sim_in_ready", W'(bus.in_ready), W'(1));
    chk("sim_count", W'(bus.elem_count), W'(16));
    chk("sim_short", W'(bus.short_vec), W'(0));
    tick();
    chk("sim_consumed", W'(bus.vec_valid), W'(0));

    // ---- reset mid-fill after 7 beats
    for (int i = 0; i < 7; i++) beat(z_t'(8'h70 + i), 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_in_ready", W'(bus.in_ready), W'(0));
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      beat(z_t'(100 + i), 1'b0);
      if (i == 8)     chk("mid_no_stale_vec_a", W'(bus.vec_valid), W'(0));
      if (i == N - 2) chk("mid_no_stale_vec_b", W'(bus.vec_valid), W'(0));
    end
    for (int i = 0; i < N; i++) exp_v[i] = z_t'(100 + i);
    chk("mid_valid", W'(bus.vec_valid), W'(1));
    chk("mid_elem0", W'(bus.vec_out[0]), W'(100));
    chk("mid_vec_out", W'(bus.vec_out), W'(exp_v));
    chk("mid_count", W'(bus.elem_count), W'(16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
